// File: rtl/vt512_pkg.sv
// Shared types and constants for the VT512 Wishbone image master.
// These are the FSM state encoding, the VT512 slave window bases and the
// per-word address stride.
package vt512_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_REQ       = 3'd2,
        ST_GAP       = 3'd3,
        ST_FINISH    = 3'd4
    } state_t;

    // VT512 slave windows ("AN" + window letter in the third byte)
    localparam logic [31:0] VT512_ADR_CTRL   = 32'h414E_4300;
    localparam logic [31:0] VT512_ADR_WEIGHT = 32'h414E_5700;
    localparam logic [31:0] VT512_ADR_BIAS   = 32'h414E_4200;
    localparam logic [31:0] VT512_ADR_IMAGE  = 32'h414E_4900;

    // Byte distance between consecutive 32-bit words
    localparam logic [31:0] VT512_WORD_STRIDE = 32'd4;

endpackage

// File: rtl/vt512_sync_fifo.sv
// Single-clock FIFO with push/pop/flush, full/empty flags and fill level.
// FIFO_DEPTH must be a power of two (>= 2). The head word is visible on
// data_o whenever empty_o is low. Flush takes priority over push and pop.
module vt512_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              push_i,
    input  logic [DATA_WIDTH-1:0]             data_i,
    input  logic                              pop_i,
    input  logic                              flush_i,
    output logic [DATA_WIDTH-1:0]             data_o,
    output logic                              full_o,
    output logic                              empty_o,
    output logic [$clog2(FIFO_DEPTH):0]       level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  do_push, do_pop;

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (level_o == (AW+1)'(FIFO_DEPTH));
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next pointer values; a flush empties the FIFO in one cycle
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers gate reads
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/vt512_wb_image_master.sv
// Wishbone classic-cycle write initiator streaming pixel words to a slave.
// Pixel stream handshake: a word moves when pix_valid_i and pix_ready_o are
// both high on a rising edge; the source must hold data stable while valid
// is high and unaccepted.
// Optional feature: define VT512_WB_TIMEOUT_EN to abort a cycle that waits
// TIMEOUT_CYCLES with stb high and no termination (treated like err_i).
module vt512_wb_image_master
    import vt512_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  start_i,
    input  logic [31:0]           base_adr_i,
    input  logic [15:0]           word_count_i,
    input  logic                  addr_inc_i,
    input  logic                  pix_valid_i,
    input  logic [DATA_WIDTH-1:0] pix_data_i,
    output logic                  pix_ready_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [3:0]            wbm_sel_o,
    output logic [31:0]           wbm_adr_o,
    output logic [DATA_WIDTH-1:0] wbm_dat_o,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_err_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [15:0]           words_sent_o,
    output state_t                dbg_state_o
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_t                state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic [31:0]           adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  inc_q, inc_d;
    logic [15:0]           sent_q, sent_d;
    logic [15:0]           acc_q, acc_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;
    logic                  push, pop, flush, timeout;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_full, fifo_empty;
    logic [LW-1:0]         fifo_level, level_d;

    assign push = pix_valid_i & ready_q;

    vt512_sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (wb_clk_i),
        .rst_ni (wb_rst_ni),
        .push_i (push),
        .data_i (pix_data_i),
        .pop_i  (pop),
        .flush_i(flush),
        .data_o (fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .level_o(fifo_level)
    );

`ifdef VT512_WB_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;

    // Count cycles spent in REQ; restarts for every new bus cycle
    always_comb begin
        tmo_d = '0;
        if (state_q == ST_REQ) tmo_d = tmo_q + 16'd1;
    end

    // Timeout counter register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) tmo_q <= '0;
        else            tmo_q <= tmo_d;
    end

    assign timeout = (state_q == ST_REQ) && (tmo_q == 16'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Next state, bus request, counters and registered status outputs
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        cnt_d   = cnt_q;
        inc_d   = inc_q;
        sent_d  = sent_q;
        acc_d   = acc_q;
        err_d   = err_q;
        pop     = 1'b0;
        flush   = 1'b0;

        if (push) acc_d = acc_q + 16'd1;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    adr_d   = base_adr_i;
                    cnt_d   = word_count_i;
                    inc_d   = addr_inc_i;
                    sent_d  = '0;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    state_d = (word_count_i == 16'd0) ? ST_FINISH : ST_WAIT_DATA;
                end
            end
            // GAP keeps the bus idle for one cycle but may load the next word
            ST_WAIT_DATA, ST_GAP: begin
                if (!fifo_empty) begin
                    cyc_d   = 1'b1;
                    dat_d   = fifo_head;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_REQ: begin
                if (wbm_err_i || timeout) begin
                    err_d   = 1'b1;
                    cyc_d   = 1'b0;
                    flush   = 1'b1;
                    state_d = ST_FINISH;
                end else if (wbm_ack_i) begin
                    pop     = 1'b1;
                    cyc_d   = 1'b0;
                    sent_d  = sent_q + 16'd1;
                    if (inc_q) adr_d = adr_q + VT512_WORD_STRIDE;
                    state_d = (sent_d == cnt_q) ? ST_FINISH : ST_GAP;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        level_d = flush ? '0 : (fifo_level + LW'(push) - LW'(pop));
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_FINISH);
        ready_d = ((state_d == ST_WAIT_DATA) || (state_d == ST_REQ) || (state_d == ST_GAP))
                  && (level_d != LW'(FIFO_DEPTH)) && (acc_d < cnt_d);
    end

    // State and output registers; reset drops the bus cycle immediately
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            cnt_q   <= '0;
            inc_q   <= 1'b0;
            sent_q  <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
            inc_q   <= inc_d;
            sent_q  <= sent_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign wbm_cyc_o    = cyc_q;
    assign wbm_stb_o    = cyc_q;
    assign wbm_we_o     = cyc_q;
    assign wbm_sel_o    = {4{cyc_q}};
    assign wbm_adr_o    = adr_q;
    assign wbm_dat_o    = dat_q;
    assign pix_ready_o  = ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign words_sent_o = sent_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_vt512_wb_image_master.sv
// Directed testbench for vt512_wb_image_master with a behavioural Wishbone
// slave (registered ack, optional error injection) and a queued pixel source.
module tb_vt512_wb_image_master;
    import vt512_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base;
    logic [15:0] count;
    logic        inc;
    logic        pix_valid = 1'b0;
    logic [31:0] pix_data  = '0;
    logic        pix_ready;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;
    logic        busy, done, err;
    logic [15:0] words_sent;
    state_t      dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    // slave model controls and logs
    logic        ack_en   = 1'b1;
    int          ack_lat  = 1;
    int          err_on   = 0;
    int          wait_cnt = 0;
    int          term_cnt = 0;
    int          stb_cycles = 0;
    int          done_cnt = 0;
    logic [31:0] adr_log[$];
    logic [31:0] dat_log[$];
    logic [31:0] sel_log[$];

    // pixel source
    logic [31:0] pix_q[$];
    int          dly_q[$];
    bit          took = 1'b0;
    int          taken = 0;

    vt512_wb_image_master #(
        .DATA_WIDTH(32),
        .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .start_i     (start),
        .base_adr_i  (base),
        .word_count_i(count),
        .addr_inc_i  (inc),
        .pix_valid_i (pix_valid),
        .pix_data_i  (pix_data),
        .pix_ready_o (pix_ready),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (dat),
        .wbm_ack_i   (wb_ack),
        .wbm_err_i   (wb_err),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .words_sent_o(words_sent),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Slave: terminates after ack_lat+1 stb cycles; err replaces the err_on-th termination
    always @(negedge clk) begin
        if (cyc && stb && !wb_ack && !wb_err) begin
            wait_cnt++;
            if (ack_en && wait_cnt > ack_lat) begin
                term_cnt++;
                if (term_cnt == err_on) begin
                    wb_err = 1'b1;
                end else begin
                    wb_ack = 1'b1;
                    adr_log.push_back(adr);
                    dat_log.push_back(dat);
                    sel_log.push_back({27'd0, we, sel});
                end
            end
        end else begin
            wb_ack   = 1'b0;
            wb_err   = 1'b0;
            wait_cnt = 0;
        end
        if (stb)  stb_cycles++;
        if (done) done_cnt++;
    end

    // Pixel source: record handshake at the edge, update drive at negedge
    always @(posedge clk) took = pix_valid && pix_ready;

    always @(negedge clk) begin
        if (took && pix_q.size() > 0) begin
            pix_q.delete(0);
            dly_q.delete(0);
            taken++;
        end
        took = 1'b0;
        if (pix_q.size() > 0 && dly_q[0] > 0) begin
            dly_q[0] = dly_q[0] - 1;
            pix_valid = 1'b0;
        end else if (pix_q.size() > 0) begin
            pix_valid = 1'b1;
            pix_data  = pix_q[0];
        end else begin
            pix_valid = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        adr_log.delete();
        dat_log.delete();
        sel_log.delete();
        term_cnt   = 0;
        stb_cycles = 0;
        done_cnt   = 0;
        taken      = 0;
    endtask

    task automatic push_pix(input logic [31:0] d, input int dly);
        pix_q.push_back(d);
        dly_q.push_back(dly);
    endtask

    task automatic flush_src();
        pix_q.delete();
        dly_q.delete();
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the start edge
    task automatic do_start(input logic [31:0] b, input logic [15:0] c, input logic i);
        start = 1'b1;
        base  = b;
        count = c;
        inc   = i;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_stb(input string tag, input int budget);
        int n = 0;
        while (!stb && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_stb_seen"}, {31'd0, stb}, 32'd1);
    endtask

    initial begin
        logic [31:0] exp_adr [4];
        exp_adr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        rst_n = 1'b0;
        start = 1'b0;
        base  = '0;
        count = '0;
        inc   = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_cyc", {31'd0, cyc}, 32'd0);
        check("rst_stb", {31'd0, stb}, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_sel", {28'd0, sel}, 32'd0);
        check("rst_adr", adr, 32'd0);
        check("rst_dat", dat, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ready", {31'd0, pix_ready}, 32'd0);
        check("rst_words", {16'd0, words_sent}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        rst_n = 1'b1;
        @(negedge clk);

        // fixed address, three words
        clear_logs();
        push_pix(32'hA1, 0);
        push_pix(32'hA2, 0);
        push_pix(32'hA3, 0);
        do_start(VT512_ADR_IMAGE, 16'd3, 1'b0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_done("t1", 60);
        check("t1_words", {16'd0, words_sent}, 32'd3);
        check("t1_nwr", adr_log.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("t1_adr", adr_log[i], VT512_ADR_IMAGE);
            check("t1_dat", dat_log[i], 32'hA1 + i);
            check("t1_we_sel", sel_log[i], 32'h1F);
        end
        check("t1_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        check("t1_done_low", {31'd0, done}, 32'd0);
        check("t1_busy_low", {31'd0, busy}, 32'd0);
        check("t1_done_cnt", done_cnt, 32'd1);
        check("t1_stb_cycles", stb_cycles, 32'd6);

        // incrementing address wraps past 2^32
        flush_src();
        clear_logs();
        for (int i = 0; i < 4; i++) push_pix(32'hE0 + i, 0);
        do_start(32'hFFFF_FFF8, 16'd4, 1'b1);
        wait_done("t2", 80);
        check("t2_words", {16'd0, words_sent}, 32'd4);
        check("t2_nwr", adr_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t2_adr", adr_log[i], exp_adr[i]);
            check("t2_dat", dat_log[i], 32'hE0 + i);
        end
        @(negedge clk);

        // source stall after word 1; five words offered for count 2
        flush_src();
        clear_logs();
        push_pix(32'hB1, 0);
        push_pix(32'hB2, 10);
        push_pix(32'hB3, 0);
        push_pix(32'hB4, 0);
        push_pix(32'hB5, 0);
        do_start(32'h0000_1000, 16'd2, 1'b1);
        wait_done("t3", 80);
        check("t3_words", {16'd0, words_sent}, 32'd2);
        check("t3_nwr", adr_log.size(), 32'd2);
        check("t3_adr1", adr_log[1], 32'h0000_1004);
        check("t3_dat1", dat_log[1], 32'hB2);
        check("t3_stb_cycles", stb_cycles, 32'd4);
        check("t3_ready", {31'd0, pix_ready}, 32'd0);
        @(negedge clk);
        check("t3_taken", taken, 32'd2);
        check("t3_left", pix_q.size(), 32'd3);

        // error on second write
        flush_src();
        clear_logs();
        err_on = 2;
        for (int i = 0; i < 4; i++) push_pix(32'hC1 + i, 0);
        do_start(VT512_ADR_IMAGE, 16'd4, 1'b1);
        wait_done("t4", 60);
        check("t4_err", {31'd0, err}, 32'd1);
        check("t4_words", {16'd0, words_sent}, 32'd1);
        check("t4_ready", {31'd0, pix_ready}, 32'd0);
        check("t4_nwr", adr_log.size(), 32'd1);
        check("t4_dat0", dat_log[0], 32'hC1);
        @(negedge clk);
        check("t4_busy_low", {31'd0, busy}, 32'd0);
        check("t4_err_sticky", {31'd0, err}, 32'd1);
        check("t4_done_cnt", done_cnt, 32'd1);
        err_on = 0;
        flush_src();

        // next start clears err_o
        clear_logs();
        push_pix(32'hD1, 0);
        do_start(VT512_ADR_IMAGE, 16'd1, 1'b0);
        check("t5_err_clr", {31'd0, err}, 32'd0);
        check("t5_words_clr", {16'd0, words_sent}, 32'd0);
        wait_done("t5", 40);
        check("t5_words", {16'd0, words_sent}, 32'd1);
        check("t5_dat", dat_log[0], 32'hD1);
        @(negedge clk);
        flush_src();

        // slave never terminates
        clear_logs();
        ack_en = 1'b0;
        push_pix(32'hF1, 0);
        do_start(VT512_ADR_IMAGE, 16'd1, 1'b0);
`ifdef VT512_WB_TIMEOUT_EN
        wait_done("t6", 40);
        check("t6_err", {31'd0, err}, 32'd1);
        check("t6_words", {16'd0, words_sent}, 32'd0);
        @(negedge clk);
        check("t6_stb_cycles", stb_cycles, 32'd8);
        flush_src();
        clear_logs();
        push_pix(32'h61, 0);
        do_start(VT512_ADR_IMAGE, 16'd1, 1'b0);
        wait_stb("t7", 20);
        repeat (3) @(negedge clk);
`else
        repeat (30) @(negedge clk);
        check("t6_stb_held", {31'd0, stb}, 32'd1);
        check("t6_cyc_held", {31'd0, cyc}, 32'd1);
        check("t6_busy", {31'd0, busy}, 32'd1);
        check("t6_err", {31'd0, err}, 32'd0);
        check("t6_no_done", done_cnt, 32'd0);
`endif

        // asynchronous reset during REQ
        #1 rst_n = 1'b0;
        #1;
        check("t7_cyc", {31'd0, cyc}, 32'd0);
        check("t7_stb", {31'd0, stb}, 32'd0);
        check("t7_busy", {31'd0, busy}, 32'd0);
        check("t7_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        @(negedge clk);
        check("t7_done", {31'd0, done}, 32'd0);
        flush_src();
        check("t7_done_cnt", done_cnt, 32'd0);
        rst_n  = 1'b1;
        ack_en = 1'b1;
        @(negedge clk);

        // zero-length transfer
        clear_logs();
        do_start(VT512_ADR_IMAGE, 16'd0, 1'b1);
        check("t8_done", {31'd0, done}, 32'd1);
        check("t8_busy", {31'd0, busy}, 32'd1);
        check("t8_cyc", {31'd0, cyc}, 32'd0);
        @(negedge clk);
        check("t8_done_low", {31'd0, done}, 32'd0);
        check("t8_busy_low", {31'd0, busy}, 32'd0);
        check("t8_stb_cycles", stb_cycles, 32'd0);
        check("t8_done_cnt", done_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vt512_wb_image_master.md
# vt512_wb_image_master

Wishbone classic-cycle initiator that streams image pixel words into the VT512 accelerator's image-data window (0x414E_4900) or any other slave address range. Words arrive on a valid/ready pixel stream, are buffered in a small FIFO, and are issued as single write cycles with optional address increment. The block sits between the host-side pixel source (SoC DMA or test harness) and the VT512 Wishbone slave port, and reports completion and bus errors.

## Interface
- DATA_WIDTH, 32, pixel word and Wishbone data width
- FIFO_DEPTH, 4, pixel buffer entries (power of two, ≥2)
- TIMEOUT_CYCLES, 255, maximum cycles stb may wait for ack (used only with timeout feature)
- wb_clk_i  in  1  single clock; all logic on rising edge
- wb_rst_ni  in  1  reset, asynchronous assert, active-low
- start_i  in  1  start a transfer (sampled in IDLE only)
- base_adr_i  in  32  first write address, latched on start
- word_count_i  in  16  words to send, latched on start
- addr_inc_i  in  1  1: address += 4 per word; 0: fixed address
- pix_valid_i  in  1  pixel word valid
- pix_data_i  in  DATA_WIDTH  pixel word
- pix_ready_o  out  1  word accepted when valid & ready
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls
- wbm_sel_o  out  4  byte selects, always 4'hF during a cycle
- wbm_adr_o  out  32  address
- wbm_dat_o  out  DATA_WIDTH  write data
- wbm_ack_i, wbm_err_i  in  1 each  slave termination
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse at transfer end (normal or error)
- err_o  out  1  sticky error, cleared by next accepted start
- words_sent_o  out  16  acked words in current/last transfer

## Operation
- States: IDLE, WAIT_DATA, REQ, GAP, FINISH.
- IDLE: start_i latches base/count/inc, clears err_o and words_sent_o, goes WAIT_DATA; count 0 goes directly FINISH, no bus activity. start_i outside IDLE ignored.
- pix_ready_o = busy_o & ~fifo_full & (accepted < count); never accepts more than word_count_i words.
- WAIT_DATA: when FIFO non-empty, register adr/dat from FIFO head, assert cyc/stb/we/sel, go REQ.
- REQ: outputs held stable until ack or err. On ack: pop FIFO, words_sent++, address += 4 if inc; if words_sent reaches count go FINISH, else GAP. cyc/stb drop on the same edge.
- GAP: one idle bus cycle (required by registered-ack slaves that hold ack while stb high), then WAIT_DATA.
- err_i in REQ (or ack & err together, err wins): set err_o, drop cycle, flush FIFO, stop accepting, go FINISH.
- FINISH: done_o high one cycle, return IDLE.
- Address wraps modulo 2^32 without flag.

## Timing
- Reset values: all Wishbone outputs 0, wbm_adr_o/wbm_dat_o 0, busy_o/done_o/err_o 0, pix_ready_o 0, words_sent_o 0, FIFO empty, state IDLE.
- All outputs registered. stb rises the cycle after the FIFO holds a word in WAIT_DATA.
- Zero-wait slave acking next cycle: one word per 3 cycles (REQ, ack, GAP).
- busy_o high from cycle after start through FINISH inclusive.
- Reset mid-transfer aborts immediately: cyc/stb low asynchronously, no done_o.

## Configuration
- VT512_WB_TIMEOUT_EN defined: counter runs while stb high; reaching TIMEOUT_CYCLES without ack/err is handled exactly as err_i (err_o set, flush, FINISH).
- Undefined: no counter, REQ waits indefinitely for termination.

## Structure
- vt512_pkg: state enum, VT512_ADR_CTRL/WEIGHT/BIAS/IMAGE address constants, word-stride constant (4).
- Sub-module vt512_sync_fifo (DATA_WIDTH, FIFO_DEPTH; push/pop/full/empty/flush), reusable elsewhere.

## Test plan
- start, base 0x414E_4900, count 3, inc 0, pixels 0xA1,0xA2,0xA3, slave acks 1 cycle after stb -> three writes all at 0x414E_4900, data in order, sel 4'hF, done_o one pulse, words_sent_o 3.
- count 4, inc 1, base 0xFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Pixel source stalls 10 cycles after word 1 -> cyc low during stall, no extra cycle; 5 valid words offered for count 2 -> only 2 accepted.
- err_i on second write of count 4 -> err_o 1, words_sent_o 1, done_o pulse, pix_ready_o 0; next start clears err_o.
- With VT512_WB_TIMEOUT_EN, TIMEOUT_CYCLES 8, slave never acks -> err_o set after 8 stb cycles; without macro stb stays high.
- wb_rst_ni low during REQ -> cyc/stb 0 before next edge, busy_o 0, no done_o; count 0 start -> done_o next cycle, no cyc.
